// File: rtl/fifo_bus_reader.sv
// Drains a slave FIFO over a simple select/address bus, one word at a time,
// handing each captured word downstream through a valid/ready holding stage.
module fifo_bus_reader #(
   parameter int unsigned POLL_LIMIT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  base_addr,
   input  logic [5:0]  max_words,
   output logic        m_sel,
   output logic        m_wr,
   output logic [7:0]  m_address,
   output logic [31:0] m_din,
   input  logic [31:0] s_dout,
   input  logic [5:0]  s_fifo_cnt,
   input  logic [5:0]  s_fifo_flag,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [5:0]  word_count
);

   localparam int unsigned PW   = $clog2(POLL_LIMIT + 1);
   localparam int unsigned AW   = 8;
   localparam int unsigned CW   = 6;
   localparam int unsigned DW   = 32;

   typedef enum logic [2:0] {IDLE, STAT, READ, CAPT, HOLD, DONE} state_t;

   state_t          state, state_n;
   logic [AW-1:0]   addr, addr_n;
   logic [CW-1:0]   max_q, max_n;
   logic [PW-1:0]   poll, poll_n;
   logic [DW-1:0]   data_n;
   logic            valid_n;
   logic            err_n;
   logic [CW-1:0]   wc_n;
   logic            fifo_empty;
   logic            unused_flags;

   assign fifo_empty   = s_fifo_flag[1] | (s_fifo_cnt == CW'(0));
   assign unused_flags = &{1'b0, s_fifo_flag[4:2], s_fifo_flag[0]};

   // Read-only master: write strobe and write data are permanently tied off.
   assign m_wr  = 1'b0;
   assign m_din = DW'(0);

   // Next-state and datapath update.
   always_comb begin
      state_n = state;
      addr_n  = addr;
      max_n   = max_q;
      poll_n  = poll;
      data_n  = out_data;
      valid_n = out_valid;
      err_n   = err;
      wc_n    = word_count;
      case (state)
         IDLE: begin
            if (start) begin
               addr_n  = base_addr;
               max_n   = max_words;
               wc_n    = CW'(0);
               err_n   = 1'b0;
               poll_n  = PW'(0);
               state_n = STAT;
            end
         end
         STAT: begin
            if (!fifo_empty) begin
               poll_n  = PW'(0);
               state_n = READ;
            end else if (max_q == CW'(0)) begin
               state_n = DONE;
            end else if (poll == PW'(POLL_LIMIT - 1)) begin
               err_n   = 1'b1;
               state_n = DONE;
            end else begin
               poll_n  = PW'(poll + PW'(1));
            end
         end
         READ: state_n = CAPT;
         CAPT: begin
            // A read error discards the word rather than passing it on.
            if (s_fifo_flag[5]) begin
               err_n   = 1'b1;
               state_n = DONE;
            end else begin
               data_n  = s_dout;
               valid_n = 1'b1;
               wc_n    = CW'(word_count + CW'(1));
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               valid_n = 1'b0;
               if ((max_q != CW'(0)) && (word_count == max_q)) state_n = DONE;
               else                                            state_n = STAT;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and registered outputs; bus outputs are decoded from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         addr       <= AW'(0);
         max_q      <= CW'(0);
         poll       <= PW'(0);
         out_data   <= DW'(0);
         out_valid  <= 1'b0;
         err        <= 1'b0;
         word_count <= CW'(0);
         m_sel      <= 1'b0;
         m_address  <= AW'(0);
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         max_q      <= max_n;
         poll       <= poll_n;
         out_data   <= data_n;
         out_valid  <= valid_n;
         err        <= err_n;
         word_count <= wc_n;
         m_sel      <= (state_n == READ);
         m_address  <= (state_n == IDLE) ? AW'(0) : addr_n;
         busy       <= (state_n != IDLE);
         done       <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_fifo_bus_reader.sv
// Directed bench for fifo_bus_reader: a two-FIFO slave model at 8'h20/8'h21
// and a scoreboard of expected output words.
module tb_fifo_bus_reader;

   localparam int unsigned POLL_LIMIT = 16;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  base_addr = 8'h00;
   logic [5:0]  max_words = 6'd0;
   logic        out_ready = 1'b1;
   logic        m_sel, m_wr;
   logic [7:0]  m_address;
   logic [31:0] m_din, s_dout, out_data;
   logic [5:0]  s_fifo_cnt, s_fifo_flag, word_count;
   logic        out_valid, busy, done, err;

   fifo_bus_reader #(.POLL_LIMIT(POLL_LIMIT)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .max_words(max_words), .m_sel(m_sel), .m_wr(m_wr), .m_address(m_address),
      .m_din(m_din), .s_dout(s_dout), .s_fifo_cnt(s_fifo_cnt),
      .s_fifo_flag(s_fifo_flag), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done), .err(err),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Slave model: index 0 is FIFO 8'h20, index 1 is FIFO 8'h21.
   logic [31:0] mem [2][64];
   int          wr_ptr [2];
   int          rd_ptr [2];
   logic [31:0] dout_r = 32'h0;
   logic        flag5_r = 1'b0;
   int          pops = 0;
   int          err_target = -1;
   logic        sel_idx;

   assign sel_idx     = (m_address == 8'h21);
   assign s_fifo_cnt  = 6'(wr_ptr[sel_idx] - rd_ptr[sel_idx]);
   assign s_fifo_flag = {flag5_r, 3'b000, s_fifo_cnt == 6'd0, s_fifo_cnt == 6'd63};
   assign s_dout      = dout_r;

   always @(posedge clk) begin
      flag5_r <= 1'b0;
      if (m_sel && !m_wr) begin
         dout_r          <= mem[sel_idx][6'(rd_ptr[sel_idx])];
         rd_ptr[sel_idx] <= rd_ptr[sel_idx] + 1;
         pops            <= pops + 1;
         flag5_r         <= (pops + 1 == err_target);
      end
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb [$];
   logic [7:0]  cur_addr = 8'h00;
   int          n_wait;
   int          xfer_at [$];
   bit          sel_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int idx, input int n, input int m0);
      for (int k = 0; k < n; k++) begin
         mem[idx][6'(wr_ptr[idx])] = 32'(32'h1111 * (m0 + k));
         wr_ptr[idx]++;
      end
   endtask

   task automatic push_exp(input int n, input int m0);
      for (int k = 0; k < n; k++) sb.push_back(32'(32'h1111 * (m0 + k)));
   endtask

   // Called at a negedge; returns at the negedge where the drain sits in STAT.
   task automatic do_start(input logic [7:0] a, input logic [5:0] mw);
      start = 1'b1; base_addr = a; max_words = mw; cur_addr = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Watches the drain until done, scoring words and bus accesses.
   task automatic run(input int budget);
      n_wait = 0; sel_seen = 0; xfer_at.delete();
      forever begin
         if (m_sel) begin
            sel_seen = 1;
            check("m_address", 32'(m_address), 32'(cur_addr));
            check("m_wr_m_din", {m_wr, m_din[30:0]}, 32'h0);
         end
         if (out_valid && out_ready) begin
            xfer_at.push_back(n_wait);
            if (sb.size() == 0) check("extra_word", 32'(sb.size()), 32'd1);
            else                check("out_data", out_data, sb.pop_front());
         end
         if (done) break;
         if (n_wait >= budget) begin
            check("timeout_done", 32'(done), 32'd1);
            break;
         end
         @(negedge clk);
         n_wait++;
      end
   endtask

   initial begin
      logic [31:0] exp_first;
      int          saved_pops;

      // Reset values, observed before any clock edge.
      #1;
      check("rst_bus", {m_sel, m_wr, m_address, m_din[21:0]}, 32'h0);
      check("rst_m_din", m_din, 32'h0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_flags", {26'b0, out_valid, busy, done, err, 2'b0}, 32'h0);
      check("rst_word_count", 32'(word_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Eight words, drain until empty.
      fill(1, 8, 1);
      push_exp(8, 1);
      do_start(8'h21, 6'd0);
      run(100);
      check("t1_cycles", 32'(n_wait), 32'd33);
      check("t1_first_xfer", 32'(xfer_at.size() > 0 ? xfer_at[0] : -1), 32'd3);
      for (int k = 1; k < xfer_at.size(); k++)
         check("t1_spacing", 32'(xfer_at[k] - xfer_at[k-1]), 32'd4);
      check("t1_nwords", 32'(xfer_at.size()), 32'd8);
      check("t1_word_count", 32'(word_count), 32'd8);
      check("t1_err", 32'(err), 32'd0);
      @(negedge clk);
      check("t1_idle", {23'b0, busy, m_address}, 32'h0);

      // Counted drain of three words out of eight.
      fill(1, 8, 1);
      push_exp(3, 1);
      do_start(8'h21, 6'd3);
      run(100);
      check("t2_word_count", 32'(word_count), 32'd3);
      check("t2_err", 32'(err), 32'd0);
      check("t2_sb_left", 32'(sb.size()), 32'd0);
      check("t2_fifo_left", 32'(wr_ptr[1] - rd_ptr[1]), 32'd5);
      @(negedge clk);
      push_exp(5, 4);
      do_start(8'h21, 6'd0);
      run(100);
      check("t2b_word_count", 32'(word_count), 32'd5);
      @(negedge clk);

      // Empty FIFO with a word limit times out on polling.
      push_exp(0, 0);
      do_start(8'h20, 6'd2);
      run(100);
      check("t3_no_sel", 32'(sel_seen), 32'd0);
      check("t3_cycles", 32'(n_wait), 32'(POLL_LIMIT));
      check("t3_err", 32'(err), 32'd1);
      check("t3_word_count", 32'(word_count), 32'd0);
      @(negedge clk);

      // Downstream stall holds the first word.
      fill(1, 2, 9);
      push_exp(2, 9);
      out_ready = 1'b0;
      do_start(8'h21, 6'd2);
      for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
      check("t4_valid_arrived", 32'(out_valid), 32'd1);
      exp_first = sb.pop_front();
      for (int n = 0; n < 10; n++) begin
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_data", out_data, exp_first);
         check("t4_hold_nosel", 32'(m_sel), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      run(60);
      check("t4_word_count", 32'(word_count), 32'd2);
      check("t4_err", 32'(err), 32'd0);
      check("t4_sb_left", 32'(sb.size()), 32'd0);
      @(negedge clk);

      // Read error on the second capture.
      fill(1, 3, 11);
      push_exp(1, 11);
      err_target = pops + 2;
      do_start(8'h21, 6'd0);
      run(60);
      check("t5_err", 32'(err), 32'd1);
      check("t5_word_count", 32'(word_count), 32'd1);
      check("t5_sb_left", 32'(sb.size()), 32'd0);
      err_target = -1;
      wr_ptr[1] = rd_ptr[1];
      @(negedge clk);

      // Reset during READ, then a start while busy must be ignored.
      fill(1, 3, 14);
      do_start(8'h21, 6'd0);
      for (int n = 0; n < 20 && !m_sel; n++) @(negedge clk);
      check("t6_in_read", 32'(m_sel), 32'd1);
      saved_pops = pops;
      #1 reset_n = 1'b0;
      #1;
      check("t6_rst_bus", {m_sel, m_wr, m_address, 22'b0}, 32'h0);
      check("t6_rst_m_din", m_din, 32'h0);
      check("t6_rst_out", out_data, 32'h0);
      check("t6_rst_flags", {26'b0, out_valid, busy, done, err, 2'b0}, 32'h0);
      check("t6_rst_word_count", 32'(word_count), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         check("t6_quiet", {30'b0, m_sel, busy}, 32'h0);
         @(negedge clk);
      end
      check("t6_no_pop", 32'(pops), 32'(saved_pops));
      push_exp(3, 14);
      do_start(8'h21, 6'd0);
      start = 1'b1; base_addr = 8'h20; max_words = 6'd1;
      @(negedge clk);
      start = 1'b0;
      run(60);
      check("t6_word_count", 32'(word_count), 32'd3);
      check("t6_err", 32'(err), 32'd0);
      check("t6_sb_left", 32'(sb.size()), 32'd0);
      check("t6_fifo20_untouched", 32'(rd_ptr[0]), 32'd0);
      @(negedge clk);
      check("t6_idle", {23'b0, busy, m_address}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
